player_datapath: RTL and testbench
==================================

Name: player_datapath

Overview:
Datapath and pacing companion for the player ship's drawing FSM. It synchronises the up/down keys toward the FSM and generates the per-frame draw_enable strobe. It consumes the FSM's command strobes (y_pos_mod, y_neg_mod, add_x, add_y, colour, write_en, continue_draw), holds the ship's Y position, and drives registered pixel coordinates, colour and plot to the VGA adapter.

Parameters:
X_POS, 8'd4, fixed left column of the ship in the 160x120 frame.
Y_INIT, 7'd58, ship top-row Y after reset.
Y_MAX, 7'd117, largest legal ship top row (ship is 3 rows tall, so 117+2 = 119).
FRAME_DIV, 833333, clk cycles per frame (50 MHz / 60 Hz); must be >= 2.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
key_up_n  input  1  raw active-low up button, asynchronous to clk.
key_down_n  input  1  raw active-low down button, asynchronous to clk.
y_pos_mod  input  1  FSM strobe: move ship up one row.
y_neg_mod  input  1  FSM strobe: move ship down one row.
add_x  input  1  pixel column offset (0..1).
add_y  input  2  pixel row offset (0..2; value 3 is illegal).
colour  input  3  pixel colour from the FSM.
write_en  input  1  FSM pixel-write strobe.
continue_draw  input  1  FSM end-of-sequence strobe.
up  output  1  synchronised, active-high up request to the FSM.
down  output  1  synchronised, active-high down request to the FSM.
draw_enable  output  1  one-cycle frame strobe to the FSM.
vga_x  output  8  pixel X to the VGA adapter.
vga_y  output  7  pixel Y to the VGA adapter.
vga_colour  output  3  pixel colour to the VGA adapter.
vga_plot  output  1  VGA write enable.
ship_y  output  7  current ship top row, for collision logic.
busy  output  1  a draw sequence is in progress.

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low. Every flop clears on assertion.
- Reset values: up = 0, down = 0, draw_enable = 0, vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0, ship_y = Y_INIT, busy = 0, frame counter = 0, synchroniser flops = 0.
- Key synchroniser:
  - Each key passes through 2 flops, then is inverted.
  - up = ~key_up_n and down = ~key_down_n, each delayed by 2 clk.
  - If both keys are asserted, both are driven; the FSM already gives priority to up.
- Frame counter:
  - Counts 0 .. FRAME_DIV-1, then wraps to 0.
  - draw_enable = 1 for exactly the one cycle the counter equals FRAME_DIV-1, and only if busy = 0 in that cycle.
  - A strobe suppressed by busy is dropped, not deferred.
- busy:
  - Set on the cycle after y_pos_mod or y_neg_mod is seen.
  - Cleared on the cycle after continue_draw is seen.
  - If both are seen in the same cycle, set wins.
- Ship position (update visible on the next cycle):
  - y_pos_mod alone: ship_y <= (ship_y == 0) ? 0 : ship_y - 1.
  - y_neg_mod alone: ship_y <= (ship_y == Y_MAX) ? Y_MAX : ship_y + 1.
  - Both asserted together: ship_y holds.
- Pixel path (1-cycle latency, registered every cycle):
  - vga_x <= X_POS + add_x.
  - vga_y <= ship_y + add_y, using the pre-update ship_y of that same cycle.
  - vga_colour <= colour.
  - vga_plot <= write_en.
- Illegal add_y = 3: vga_plot <= 0 for that cycle; all other pixel registers still load.
- Reset mid-sequence: all outputs return to their reset values immediately, asynchronously. ship_y returns to Y_INIT.

Decomposition:
- Shared package player_pkg holds:
  - screen constants SCREEN_W = 160 and SCREEN_H = 120;
  - coordinate widths X_W = 8 and Y_W = 7;
  - SHIP_W = 2 and SHIP_H = 3;
  - colour constants COL_BLACK = 3'b000 and COL_WHITE = 3'b111.
- One natural sub-module: key_sync, the 2-flop synchroniser plus invert. It is instantiated twice.

Test Plan:
- Reset: assert reset_n = 0 mid-count, then release -> ship_y = 58, all VGA outputs 0, busy = 0, draw_enable = 0.
- Frame pacing (FRAME_DIV = 4) -> draw_enable pulses on cycles 3, 7, 11 after release, each 1 cycle wide. Then hold busy via y_pos_mod with no continue_draw -> the pulse at cycle 15 is suppressed.
- Up sequence: y_pos_mod + write_en with add = (0,0) and colour 0, then 5 further offset cycles ending with continue_draw.
  - Plot 1: vga_x = 4, vga_y = 58.
  - Subsequent plots: (5,57), (4,58,colour 7), (5,58,7), (4,59), (5,59).
  - busy falls 1 cycle after continue_draw.
- Clamp top: ship_y = 0, apply y_pos_mod -> ship_y stays 0. Clamp bottom: ship_y = 117, apply y_neg_mod -> ship_y stays 117.
- Keys: key_up_n falls -> up rises exactly 2 clk later. Both keys low -> up = down = 1.
- Illegal and simultaneous: add_y = 3 with write_en = 1 -> vga_plot = 0. y_pos_mod and y_neg_mod together -> ship_y unchanged.

Source files
------------

// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : player_pkg
// Purpose  : Shared screen geometry, coordinate widths, ship size and colour
//            constants for the player ship drawing path.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package player_pkg;

  // Visible frame of the VGA adapter
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Pixel coordinate widths
  localparam int X_W = 8;
  localparam int Y_W = 7;

  // Ship footprint in pixels
  localparam int SHIP_W = 2;
  localparam int SHIP_H = 3;

  // Colours
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  // Row offsets inside the ship are 0..SHIP_H-1; anything else is illegal.
  function automatic logic row_ofs_legal(input logic [1:0] ofs);
    return (32'(ofs) < SHIP_H);
  endfunction

endpackage : player_pkg
`default_nettype wire

// File: rtl/player_datapath_key_sync.sv
`default_nettype none
// ============================================================================
// Module   : player_datapath_key_sync (module name key_sync)
// Purpose  : Two-flop synchroniser for a raw active-low push button, with the
//            output inverted to an active-high request.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            i_key_n  - raw active-low key, asynchronous to clk
//            o_key    - synchronised active-high key, 2 clk latency
// Revision : 1.0  initial release
// ============================================================================
module key_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_key
);

  // Flops hold the inverted key so that reset (all zeros) means "released".
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= ~i_key_n;
      r_sync <= r_meta;
    end
  end

  assign o_key = r_sync;

endmodule : key_sync
`default_nettype wire

// File: rtl/player_datapath.sv
`default_nettype none
// ============================================================================
// Module   : player_datapath
// Purpose  : Datapath and pacing companion for the player ship drawing FSM.
//            Synchronises the up/down keys, generates the per-frame
//            draw_enable strobe, tracks the ship's top row and registers the
//            pixel coordinates/colour/plot toward the VGA adapter.
// Ports    : clk, reset_n            - clock, async active-low reset
//            key_up_n, key_down_n    - raw active-low buttons
//            y_pos_mod, y_neg_mod    - FSM move-up / move-down strobes
//            add_x, add_y            - pixel offsets inside the ship
//            colour, write_en        - pixel colour and write strobe
//            continue_draw           - FSM end-of-sequence strobe
//            up, down                - synchronised key requests
//            draw_enable             - one-cycle frame strobe
//            vga_x/vga_y/vga_colour/vga_plot - registered pixel to VGA
//            ship_y                  - current ship top row
//            busy                    - draw sequence in progress
// Revision : 1.0  initial release
// ============================================================================
module player_datapath
  import player_pkg::*;
#(
  parameter logic [X_W-1:0] X_POS     = 8'd4,
  parameter logic [Y_W-1:0] Y_INIT    = 7'd58,
  parameter logic [Y_W-1:0] Y_MAX     = Y_W'(SCREEN_H - SHIP_H),
  parameter int             FRAME_DIV = 833333
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           key_up_n,
  input  logic           key_down_n,
  input  logic           y_pos_mod,
  input  logic           y_neg_mod,
  input  logic           add_x,
  input  logic [1:0]     add_y,
  input  logic [2:0]     colour,
  input  logic           write_en,
  input  logic           continue_draw,
  output logic           up,
  output logic           down,
  output logic           draw_enable,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic [Y_W-1:0] ship_y,
  output logic           busy
);

  localparam int             CNT_W      = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(FRAME_DIV - 1);

  // --------------------------------------------------------------------------
  // Key synchronisers
  // --------------------------------------------------------------------------
  key_sync u_sync_up (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_up_n),
    .o_key   (up)
  );

  key_sync u_sync_down (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_down_n),
    .o_key   (down)
  );

  // --------------------------------------------------------------------------
  // Frame counter and draw_enable
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_busy;
  logic             w_frame_last;

  assign w_frame_last = (r_frame_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_last) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // A frame tick that lands while a draw is running is simply lost; the FSM
  // picks up the next one.
  assign draw_enable = w_frame_last & ~r_busy;

  // --------------------------------------------------------------------------
  // busy: start of a move sets it, continue_draw clears it, set wins.
  // --------------------------------------------------------------------------
  logic w_move;
  assign w_move = y_pos_mod | y_neg_mod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
    end else if (w_move) begin
      r_busy <= 1'b1;
    end else if (continue_draw) begin
      r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;

  // --------------------------------------------------------------------------
  // Ship position with clamping at the top and bottom rows
  // --------------------------------------------------------------------------
  logic [Y_W-1:0] r_ship_y;
  logic [Y_W-1:0] w_ship_y_nxt;

  always_comb begin
    w_ship_y_nxt = r_ship_y;
    case ({y_pos_mod, y_neg_mod})
      2'b10: w_ship_y_nxt = (r_ship_y == '0)    ? '0    : r_ship_y - 1'b1;
      2'b01: w_ship_y_nxt = (r_ship_y == Y_MAX) ? Y_MAX : r_ship_y + 1'b1;
      default: w_ship_y_nxt = r_ship_y;  // idle, or both strobes cancel out
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ship_y <= Y_INIT;
    end else begin
      r_ship_y <= w_ship_y_nxt;
    end
  end

  assign ship_y = r_ship_y;

  // --------------------------------------------------------------------------
  // Pixel path: registered every cycle. vga_y uses the ship row as it stands
  // this cycle, so the first plot of a move still lands on the old row.
  // --------------------------------------------------------------------------
  logic [X_W-1:0] r_vga_x;
  logic [Y_W-1:0] r_vga_y;
  logic [2:0]     r_vga_colour;
  logic           r_vga_plot;
  logic [X_W-1:0] w_pix_x;
  logic [Y_W-1:0] w_pix_y;

  assign w_pix_x = X_POS + X_W'(add_x);
  assign w_pix_y = r_ship_y + Y_W'(add_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= COL_BLACK;
      r_vga_plot   <= 1'b0;
    end else begin
      r_vga_x      <= w_pix_x;
      r_vga_y      <= w_pix_y;
      r_vga_colour <= colour;
      // An out-of-ship row offset must never reach the frame buffer.
      r_vga_plot   <= write_en & row_ofs_legal(add_y);
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;

endmodule : player_datapath
`default_nettype wire

// File: tb/tb_player_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_datapath
// Purpose  : Directed self-checking bench for player_datapath (FRAME_DIV = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_player_datapath;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_up_n, key_down_n;
  logic       y_pos_mod, y_neg_mod;
  logic       add_x;
  logic [1:0] add_y;
  logic [2:0] colour;
  logic       write_en, continue_draw;
  logic       up, down, draw_enable, vga_plot, busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y, ship_y;
  logic [2:0] vga_colour;

  int total = 0;
  int bad   = 0;

  player_datapath #(.FRAME_DIV(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_up_n      (key_up_n),
    .key_down_n    (key_down_n),
    .y_pos_mod     (y_pos_mod),
    .y_neg_mod     (y_neg_mod),
    .add_x         (add_x),
    .add_y         (add_y),
    .colour        (colour),
    .write_en      (write_en),
    .continue_draw (continue_draw),
    .up            (up),
    .down          (down),
    .draw_enable   (draw_enable),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .ship_y        (ship_y),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    y_pos_mod = 0; y_neg_mod = 0; add_x = 0; add_y = 0;
    colour = 0; write_en = 0; continue_draw = 0;
  endtask

  // Short asynchronous reset pulse, released between clock edges.
  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_pix(input logic ax, input logic [1:0] ay, input logic [2:0] col);
    add_x = ax; add_y = ay; colour = col;
  endtask

  initial begin
    reset_n = 1'b0; key_up_n = 1'b1; key_down_n = 1'b1;
    idle_inputs();
    tick(); tick();
    reset_n = 1'b1;

    // ---- Make outputs non-zero, then reset mid-count ----
    tick();
    y_neg_mod = 1; write_en = 1; set_pix(1, 0, 3'd5);
    tick();
    idle_inputs();
    chk("pre_rst_ship_y", ship_y, 59);
    chk("pre_rst_vga_x",  vga_x, 5);
    chk("pre_rst_plot",   vga_plot, 1);
    chk("pre_rst_busy",   busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_ship_y", ship_y, 58);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_vga_colour", vga_colour, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_draw_enable", draw_enable, 0);
    chk("rst_up", up, 0);
    chk("rst_down", down, 0);
    reset_n = 1'b1;

    // ---- Frame pacing: pulses after 3, 7, 11 edges ----
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("draw_en_k%0d", k), draw_enable, ((k % 4) == 3) ? 1 : 0);
    end
    y_pos_mod = 1;
    tick();            // k = 13
    y_pos_mod = 0;
    chk("busy_hold_set", busy, 1);
    chk("busy_hold_ship_y", ship_y, 57);
    tick();            // k = 14
    tick();            // k = 15
    chk("draw_en_suppressed_k15", draw_enable, 0);
    chk("busy_still_k15", busy, 1);
    continue_draw = 1;
    tick();
    continue_draw = 0;
    chk("busy_cleared", busy, 0);

    // ---- Up sequence ----
    reset_pulse();
    tick();
    y_pos_mod = 1; write_en = 1; set_pix(0, 0, 3'd0);
    tick();
    y_pos_mod = 0;
    chk("up1_x", vga_x, 4);
    chk("up1_y", vga_y, 58);
    chk("up1_col", vga_colour, 0);
    chk("up1_plot", vga_plot, 1);
    chk("up1_ship_y", ship_y, 57);
    chk("up1_busy", busy, 1);
    set_pix(1, 0, 3'd0); tick();
    chk("up2_x", vga_x, 5);
    chk("up2_y", vga_y, 57);
    set_pix(0, 1, 3'd7); tick();
    chk("up3_x", vga_x, 4);
    chk("up3_y", vga_y, 58);
    chk("up3_col", vga_colour, 7);
    set_pix(1, 1, 3'd7); tick();
    chk("up4_x", vga_x, 5);
    chk("up4_y", vga_y, 58);
    chk("up4_col", vga_colour, 7);
    set_pix(0, 2, 3'd7); tick();
    chk("up5_x", vga_x, 4);
    chk("up5_y", vga_y, 59);
    chk("up5_busy", busy, 1);
    set_pix(1, 2, 3'd7); continue_draw = 1; tick();
    chk("up6_x", vga_x, 5);
    chk("up6_y", vga_y, 59);
    chk("up6_plot", vga_plot, 1);
    chk("up6_busy_fall", busy, 0);
    idle_inputs();
    tick();
    chk("up_end_plot", vga_plot, 0);

    // ---- Busy: set wins over continue_draw ----
    y_pos_mod = 1; continue_draw = 1;
    tick();
    idle_inputs();
    chk("busy_set_wins", busy, 1);

    // ---- Clamp top ----
    reset_pulse();
    y_pos_mod = 1;
    for (int i = 0; i < 58; i++) tick();
    chk("clamp_top_reach", ship_y, 0);
    tick();
    chk("clamp_top_hold", ship_y, 0);
    y_pos_mod = 0;

    // ---- Clamp bottom ----
    y_neg_mod = 1;
    for (int i = 0; i < 117; i++) tick();
    chk("clamp_bot_reach", ship_y, 117);
    tick();
    chk("clamp_bot_hold", ship_y, 117);
    y_neg_mod = 0;

    // ---- Keys ----
    reset_pulse();
    tick();
    key_up_n = 0;
    tick();
    chk("key_up_1clk", up, 0);
    tick();
    chk("key_up_2clk", up, 1);
    chk("key_down_idle", down, 0);
    key_down_n = 0;
    tick();
    chk("key_down_1clk", down, 0);
    tick();
    chk("key_both_up", up, 1);
    chk("key_both_down", down, 1);
    key_up_n = 1; key_down_n = 1;
    tick(); tick();
    chk("key_up_release", up, 0);
    chk("key_down_release", down, 0);

    // ---- Illegal add_y and simultaneous moves ----
    reset_pulse();
    tick();
    write_en = 1; set_pix(1, 3, 3'd3);
    tick();
    chk("illegal_plot", vga_plot, 0);
    chk("illegal_x", vga_x, 5);
    chk("illegal_y", vga_y, 61);
    chk("illegal_col", vga_colour, 3);
    idle_inputs();
    y_pos_mod = 1; y_neg_mod = 1;
    tick();
    idle_inputs();
    chk("both_mod_ship_y", ship_y, 58);
    chk("both_mod_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_player_datapath
`default_nettype wire
